// File: rtl/rriot_pkg.sv
// rriot_pkg: shared widths, address-bit positions, prescale/mode enums and terminal-count helper
package rriot_pkg;
  localparam int CNT_W = 8;
  localparam int PRE_W = 10;
  localparam int A_IRQEN = 2;
  localparam int A_SEL = 0;
  typedef enum logic [1:0] {DIV1, DIV8, DIV64, DIV1024} div_sel_e;
  typedef enum logic {DIVIDED, FREE} mode_e;
  function automatic logic [PRE_W-1:0] div_terminal(div_sel_e d);
    return d == DIV1 ? 10'd0 : d == DIV8 ? 10'd7 : d == DIV64 ? 10'd63 : 10'd1023;
  endfunction
endpackage

// File: rtl/rriot_timer_if.sv
// rriot_timer_if: timer-window access bus between the mcs6530 decode/read mux and the interval timer
interface rriot_timer_if;
  import rriot_pkg::*;
  logic cs;
  logic we_n;
  logic [2:0] A;
  logic [CNT_W-1:0] DI;
  logic [CNT_W-1:0] DO;
  logic OE;
  logic irq;
  modport master (output cs, we_n, A, DI, input DO, OE, irq);
  modport slave (input cs, we_n, A, DI, output DO, OE, irq);
endinterface

// File: rtl/rriot_prescaler.sv
// rriot_prescaler: prescale counter producing one tick per selected division, or every cycle when free
module rriot_prescaler
  import rriot_pkg::*;
(
  input  logic     phi2,
  input  logic     rst_n,
  input  logic     clr,
  input  logic     free,
  input  div_sel_e div_sel,
  output logic     tick
);
  logic [PRE_W-1:0] pre;
  assign tick = free | (pre == div_terminal(div_sel));
  // restart on a timer access or on each tick, otherwise count up towards the terminal value
  always_ff @(posedge phi2 or negedge rst_n)
    if (!rst_n) pre <= '0;
    else pre <= (clr | tick) ? '0 : pre + 1'b1;
endmodule

// File: rtl/rriot_timer.sv
// rriot_timer: mcs6530 interval timer with 8-bit down-counter, selectable prescale and maskable irq
module rriot_timer
  import rriot_pkg::*;
(
  input logic         phi2,
  input logic         rst_n,
  rriot_timer_if.slave bus
);
  logic [CNT_W-1:0] count;
  div_sel_e div_sel;
  mode_e mode;
  logic irq_flag, irq_en, tick, wr, rd_t, under;
  assign wr = bus.cs & ~bus.we_n;
  assign rd_t = bus.cs & bus.we_n & ~bus.A[A_SEL];
  assign under = tick & (count == '0);
  rriot_prescaler u_pre (
    .phi2    (phi2),
    .rst_n   (rst_n),
    .clr     (wr | rd_t),
    .free    (mode == FREE),
    .div_sel (div_sel),
    .tick    (tick)
  );
  // counter and control state; a write beats an underflow, which beats a timer-read clear
  always_ff @(posedge phi2 or negedge rst_n)
    if (!rst_n) begin
      count <= '0;
      div_sel <= DIV1;
      mode <= DIVIDED;
      irq_flag <= 1'b0;
      irq_en <= 1'b0;
    end else begin
      count <= wr ? bus.DI : tick ? count - 1'b1 : count;
      div_sel <= wr ? div_sel_e'(bus.A[1:0]) : div_sel;
      irq_en <= (wr | rd_t) ? bus.A[A_IRQEN] : irq_en;
      irq_flag <= wr ? 1'b0 : under ? 1'b1 : rd_t ? 1'b0 : irq_flag;
      mode <= wr ? DIVIDED : under ? FREE : rd_t ? DIVIDED : mode;
    end
  // read mux straight from the registers; idle bus reads as zero
  always_comb begin
    bus.OE = bus.cs & bus.we_n & rst_n;
    bus.DO = !bus.OE ? '0 : bus.A[A_SEL] ? {irq_flag, {(CNT_W-1){1'b0}}} : count;
    bus.irq = irq_flag & irq_en;
  end
endmodule

// File: tb/tb_rriot_timer.sv
// tb_rriot_timer: directed scoreboard bench for the rriot interval timer
module tb_rriot_timer;
  logic phi2 = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  int rd_id = 0;
  logic [8:0] exp_q[$];
  rriot_timer_if bif ();
  rriot_timer dut (.phi2(phi2), .rst_n(rst_n), .bus(bif));
  always #5 phi2 = ~phi2;
  task automatic cyc();
    @(posedge phi2);
    #1;
  endtask
  task automatic idle(input int n);
    bif.cs = 1'b0;
    bif.we_n = 1'b1;
    repeat (n) cyc();
  endtask
  task automatic wr(input logic [7:0] d, input logic [2:0] a);
    bif.cs = 1'b1;
    bif.we_n = 1'b0;
    bif.A = a;
    bif.DI = d;
    cyc();
    bif.cs = 1'b0;
    bif.we_n = 1'b1;
  endtask
  task automatic rd(input logic [2:0] a, input logic [7:0] e_do, input logic e_irq);
    bif.cs = 1'b1;
    bif.we_n = 1'b1;
    bif.A = a;
    exp_q.push_back({e_irq, e_do});
    cyc();
    bif.cs = 1'b0;
  endtask
  task automatic check_rst(input string name);
    @(negedge phi2);
    checks++;
    if (bif.OE !== 1'b0 || bif.DO !== 8'h00 || bif.irq !== 1'b0) begin
      failures++;
      $display("FAIL %s: OE=%b DO=%h irq=%b, required OE=0 DO=00 irq=0", name, bif.OE, bif.DO, bif.irq);
    end
  endtask
  // monitor: every presented read is matched against the next queued expectation
  always @(negedge phi2)
    if (bif.OE === 1'b1) begin
      checks++;
      rd_id++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL read%0d: unexpected read DO=%h irq=%b", rd_id, bif.DO, bif.irq);
      end else begin
        logic [8:0] e;
        e = exp_q.pop_front();
        if ({bif.irq, bif.DO} !== e) begin
          failures++;
          $display("FAIL read%0d: DO=%h irq=%b, required DO=%h irq=%b", rd_id, bif.DO, bif.irq, e[7:0], e[8]);
        end
      end
    end
  initial begin
    #200000;
    $display("FAIL watchdog: time limit expired");
    $fatal(1, "watchdog");
  end
  initial begin
    bif.cs = 1'b1;
    bif.we_n = 1'b1;
    bif.A = 3'b000;
    bif.DI = 8'h00;
    check_rst("reset_hold0");
    check_rst("reset_hold1");
    @(posedge phi2);
    #1;
    rst_n = 1'b1;
    rd(3'b001, 8'h00, 1'b0);
    rd(3'b001, 8'h80, 1'b0);
    wr(8'h03, 3'b100);
    rd(3'b100, 8'h03, 1'b0);
    rd(3'b100, 8'h02, 1'b0);
    rd(3'b100, 8'h01, 1'b0);
    rd(3'b100, 8'h00, 1'b0);
    rd(3'b001, 8'h80, 1'b1);
    rd(3'b000, 8'hFE, 1'b1);
    rd(3'b001, 8'h00, 1'b0);
    rd(3'b000, 8'hFC, 1'b0);
    wr(8'h02, 3'b001);
    idle(7);
    rd(3'b000, 8'h02, 1'b0);
    idle(7);
    rd(3'b000, 8'h01, 1'b0);
    idle(7);
    rd(3'b000, 8'h00, 1'b0);
    rd(3'b001, 8'h80, 1'b0);
    rd(3'b000, 8'hFE, 1'b0);
    idle(7);
    rd(3'b000, 8'hFD, 1'b0);
    wr(8'h01, 3'b100);
    idle(1);
    wr(8'h55, 3'b100);
    rd(3'b001, 8'h00, 1'b0);
    rd(3'b100, 8'h54, 1'b0);
    wr(8'h01, 3'b111);
    idle(1023);
    rd(3'b110, 8'h01, 1'b0);
    rd(3'b101, 8'h00, 1'b0);
    idle(475);
    rst_n = 1'b0;
    bif.cs = 1'b1;
    bif.A = 3'b001;
    check_rst("reset_mid1500");
    check_rst("reset_mid1500_hold");
    @(posedge phi2);
    #1;
    rst_n = 1'b1;
    wr(8'h01, 3'b111);
    idle(1023);
    rd(3'b110, 8'h01, 1'b0);
    idle(1023);
    rd(3'b101, 8'h00, 1'b0);
    rd(3'b101, 8'h80, 1'b1);
    rst_n = 1'b0;
    bif.cs = 1'b1;
    bif.A = 3'b000;
    check_rst("reset_after_irq");
    bif.cs = 1'b0;
    @(negedge phi2);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d reads outstanding, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
